// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage access unit and its load aligner.
package mem_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } mau_state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Size encoding 3 is treated as a misaligned (rejected) access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size_t'(size))
            BYTE:    return 1'b0;
            HALF:    return lsb[0];
            WORD:    return lsb != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half lane out of a RAM word and sign- or zero-extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] ram_rdata,
    input  logic [1:0]  addr_lsb,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    always_comb begin
        byte_sh = ram_rdata >> {addr_lsb, 3'b000};
        half_sh = ram_rdata >> {addr_lsb[1], 4'b0000};
        case (size_t'(size))
            BYTE:    data = {{24{~is_unsigned & byte_sh[7]}}, byte_sh[7:0]};
            HALF:    data = {{16{~is_unsigned & half_sh[15]}}, half_sh[15:0]};
            default: data = ram_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage responder: one aligned access per request on a fixed-latency block RAM,
// reporting completion with a single done pulse.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              done,
    output logic              misalign,
    output logic [31:0]       rdata,
    output logic              ram_en,
    output logic [3:0]        ram_be,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [2:0] CNT_INIT = 3'(RD_LATENCY - 1);

    mau_state_t        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              mis_q, mis_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       ld_data;

    mem_load_align u_align (
        .ram_rdata  (ram_rdata),
        .addr_lsb   (addr_q[1:0]),
        .size       (size_q),
        .is_unsigned(uns_q),
        .data       (ld_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            mis_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            mis_q   <= mis_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        mis_d   = mis_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    mis_d   = is_misaligned(req_size, req_addr[1:0]);
                    state_d = mis_d ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                // Stores sit out the same read latency so every access has one duration.
                if (cnt_q == 3'd0) begin
                    if (!we_q) rdata_d = ld_data;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = state_q != IDLE;
        done      = state_q == DONE;
        misalign  = (state_q == DONE) && mis_q;
        ram_en    = state_q == ISSUE;
        ram_addr  = addr_q[ADDR_W-1:2];
        rdata     = rdata_q;
        ram_be    = 4'b0000;
        if (state_q == ISSUE && we_q) begin
            case (size_t'(size_q))
                BYTE:    ram_be = BE_BYTE << addr_q[1:0];
                HALF:    ram_be = BE_HALF << addr_q[1:0];
                default: ram_be = BE_WORD;
            endcase
        end
        case (size_t'(size_q))
            BYTE:    ram_wdata = {4{wdata_q[7:0]}};
            HALF:    ram_wdata = {2{wdata_q[15:0]}};
            default: ram_wdata = wdata_q;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Random and directed accesses on two units (read latency 1 and 3), checked against a
// byte-addressed memory model and the cycle counts implied by the access rules.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req1, req3;
    logic        req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;

    logic        busy1, done1, mis1, en1, busy3, done3, mis3, en3;
    logic [31:0] rdata1, wd1, rram1, rdata3, wd3, rram3;
    logic [3:0]  be1, be3;
    logic [13:0] ra1, ra3;

    int checks = 0;
    int failures = 0;

    logic [7:0]  ref_mem [2][256];
    logic [31:0] exp_rdata [2];
    logic [31:0] mem [2][64];
    logic [31:0] rp3 [3];

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(16), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .req(req1), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy1), .done(done1), .misalign(mis1), .rdata(rdata1), .ram_en(en1),
        .ram_be(be1), .ram_addr(ra1), .ram_wdata(wd1), .ram_rdata(rram1)
    );

    mem_access_unit #(.ADDR_W(16), .RD_LATENCY(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .req(req3), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy3), .done(done3), .misalign(mis3), .rdata(rdata3), .ram_en(en3),
        .ram_be(be3), .ram_addr(ra3), .ram_wdata(wd3), .ram_rdata(rram3)
    );

    // RAM models; contents are reloaded from the reference bytes while reset is held.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int w = 0; w < 64; w++) begin
                mem[0][w] <= {ref_mem[0][4*w+3], ref_mem[0][4*w+2], ref_mem[0][4*w+1], ref_mem[0][4*w]};
                mem[1][w] <= {ref_mem[1][4*w+3], ref_mem[1][4*w+2], ref_mem[1][4*w+1], ref_mem[1][4*w]};
            end
        end else begin
            if (en1) begin
                for (int b = 0; b < 4; b++)
                    if (be1[b]) mem[0][ra1[5:0]][8*b +: 8] <= wd1[8*b +: 8];
                rram1 <= mem[0][ra1[5:0]];
            end
            if (en3) begin
                for (int b = 0; b < 4; b++)
                    if (be3[b]) mem[1][ra3[5:0]][8*b +: 8] <= wd3[8*b +: 8];
                rp3[0] <= mem[1][ra3[5:0]];
            end
        end
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign rram3 = rp3[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic obs(input int d, output logic dn, output logic ms, output logic bs,
                       output logic en, output logic [3:0] be, output logic [13:0] ra,
                       output logic [31:0] wd, output logic [31:0] rd);
        if (d == 0) begin
            dn = done1; ms = mis1; bs = busy1; en = en1; be = be1; ra = ra1; wd = wd1; rd = rdata1;
        end else begin
            dn = done3; ms = mis3; bs = busy3; en = en3; be = be3; ra = ra3; wd = wd3; rd = rdata3;
        end
    endtask

    function automatic logic [31:0] ref_load(input int d, input logic [1:0] sz, input logic un, input int a);
        int nb = 1 << sz;
        logic [31:0] v = '0;
        for (int i = 0; i < nb; i++) v |= 32'(ref_mem[d][a+i]) << (8*i);
        if (!un && nb < 4 && v[8*nb-1]) v |= ~((32'd1 << (8*nb)) - 32'd1);
        return v;
    endfunction

    task automatic run_op(input int d, input logic we, input logic [1:0] sz, input logic un,
                          input logic [15:0] ad, input logic [31:0] wdat);
        int a = int'(ad);
        logic mis = (sz == 2'd3) || (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'b00);
        int nb = 1 << sz;
        int exp_cyc = mis ? 1 : ((d == 0) ? 1 : 3) + 2;
        logic [3:0] exp_be = '0;
        logic [31:0] exp_wd = '0;
        int dcyc = -1;
        int ens = 0;
        logic dn, ms, bs, en;
        logic [3:0] be;
        logic [13:0] ra;
        logic [31:0] wd, rd;
        if (!mis) begin
            if (we) exp_be = 4'(((1 << nb) - 1) << (a % 4));
            for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wdat[8*(j % nb) +: 8];
        end
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = un; req_addr = ad; req_wdata = wdat;
        if (d == 0) req1 = 1'b1; else req3 = 1'b1;
        for (int k = 1; k <= 20 && dcyc < 0; k++) begin
            @(negedge clk);
            obs(d, dn, ms, bs, en, be, ra, wd, rd);
            if (k == 1) begin
                req1 = 1'b0; req3 = 1'b0;
                chk("busy_after_req", 32'(bs), 32'd1);
                if (!mis) begin
                    chk("issue_en", 32'(en), 32'd1);
                    chk("issue_be", 32'(be), 32'(exp_be));
                    chk("issue_addr", 32'(ra), 32'(ad[15:2]));
                    if (we) chk("issue_wdata", wd, exp_wd);
                end
            end
            if (en) ens++;
            if (dn) begin
                dcyc = k;
                if (!mis) begin
                    if (we) for (int i = 0; i < nb; i++) ref_mem[d][a+i] = wdat[8*i +: 8];
                    else exp_rdata[d] = ref_load(d, sz, un, a);
                end
                chk("done_cycle", 32'(dcyc), 32'(exp_cyc));
                chk("misalign", 32'(ms), 32'(mis));
                chk("rdata", rd, exp_rdata[d]);
            end
        end
        if (dcyc < 0) chk("done_timeout", 32'd0, 32'd1);
        chk("ram_en_count", 32'(ens), mis ? 32'd0 : 32'd1);
    endtask

    task automatic rand_op(input int d);
        int r = $urandom_range(0, 9);
        logic [1:0] sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        logic [15:0] ad = 16'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1 && sz != 2'd3) ad = ad & ~16'((1 << sz) - 1);
        run_op(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom);
    endtask

    initial begin
        int ndone, first, second;
        reset_n = 1'b0;
        req1 = 1'b0; req3 = 1'b0;
        req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[0][i] = 8'($urandom);
            ref_mem[1][i] = ref_mem[0][i];
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_en", 32'(en1), 32'd0);
        chk("rst_be", 32'(be1), 32'd0);
        chk("rst_addr", 32'(ra1), 32'd0);
        chk("rst_wdata", wd1, 32'd0);
        chk("rst_rdata", rdata1, 32'd0);
        reset_n = 1'b1;

        run_op(0, 1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF);
        run_op(0, 1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
        run_op(0, 1'b1, 2'd2, 1'b0, 16'h0010, 32'h80FF7F01);
        run_op(0, 1'b0, 2'd0, 1'b0, 16'h0013, 32'h0);
        run_op(0, 1'b0, 2'd0, 1'b1, 16'h0013, 32'h0);
        run_op(0, 1'b1, 2'd1, 1'b0, 16'h0002, 32'h00001234);
        run_op(0, 1'b0, 2'd1, 1'b0, 16'h0002, 32'h0);
        run_op(0, 1'b0, 2'd2, 1'b0, 16'h0006, 32'h0);

        // req held high: the DONE-cycle req is ignored, the following IDLE cycle accepts it
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 16'h0010; req1 = 1'b1;
        ndone = 0; first = -1; second = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done1) begin
                ndone++;
                if (first < 0) first = k; else if (second < 0) second = k;
            end
            if (k == 4) chk("hold_idle_gap", 32'(busy1), 32'd0);
            if (k == 5) begin
                chk("hold_second_busy", 32'(busy1), 32'd1);
                req1 = 1'b0;
            end
        end
        exp_rdata[0] = ref_load(0, 2'd2, 1'b0, 16);
        chk("hold_done_count", 32'(ndone), 32'd2);
        chk("hold_first_done", 32'(first), 32'd3);
        chk("hold_second_done", 32'(second), 32'd7);
        chk("hold_rdata", rdata1, exp_rdata[0]);

        repeat (40) rand_op(0);

        run_op(1, 1'b1, 2'd2, 1'b0, 16'h0020, 32'hCAFEF00D);
        run_op(1, 1'b0, 2'd2, 1'b0, 16'h0020, 32'h0);

        // reset asserted while the latency-3 unit is in WAIT
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 16'h0024; req3 = 1'b1;
        @(negedge clk);
        req3 = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy3), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy3), 32'd0);
        chk("midrst_en", 32'(en3), 32'd0);
        chk("midrst_done", 32'(done3), 32'd0);
        chk("midrst_rdata", rdata3, 32'd0);
        chk("midrst_rdata1", rdata1, 32'd0);
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_op(1, 1'b0, 2'd2, 1'b0, 16'h0024, 32'h0);

        repeat (12) rand_op(1);
        repeat (5) rand_op(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Responder side of the multi-cycle stage sequencing.
- The stage sequencer issues a one-cycle memory request during the MEM stage. This block performs the aligned byte/half/word access on a synchronous block RAM with fixed read latency, then returns a one-cycle done pulse with load data, sign- or zero-extended.
- Sits between the EX/MEM pipeline register and the data RAM.
- Lets the sequencer stall on busy instead of assuming a fixed MEM duration.

Parameters:
ADDR_W, 16, byte-address width; RAM word address is ADDR_W-2 bits
RD_LATENCY, 1, cycles from RAM enable sample edge to valid ram_rdata; legal range 1..7

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req  in  1  access request, sampled only in IDLE
req_we  in  1  1=store, 0=load
req_size  in  2  size_t: BYTE=0, HALF=1, WORD=2; 3 is illegal
req_unsigned  in  1  zero-extend load when 1
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
misalign  out  1  high only with done; access rejected
rdata  out  32  extended load data; holds value until next completed load
ram_en  out  1  RAM enable
ram_be  out  4  byte write enables; 0 for loads
ram_addr  out  ADDR_W-2  RAM word address
ram_wdata  out  32  lane-replicated store data
ram_rdata  in  32  RAM read data

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE. busy, done, misalign, ram_en, ram_be, ram_addr, ram_wdata and rdata all go to 0. ram_en drops with no clock.
- FSM states are IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req=1 latches we, size, unsigned, addr and wdata.
  - Legal and aligned -> ISSUE.
  - Misaligned or size=3 -> DONE with the misalign flag set.
  - Misaligned means HALF with addr[0]=1, or WORD with addr[1:0]!=0.
- ISSUE (1 cycle):
  - ram_en=1 and ram_addr=addr[ADDR_W-1:2].
  - Store: ram_be = BYTE 4'b0001<<addr[1:0], HALF 4'b0011<<addr[1:0], WORD 4'b1111.
  - Store: ram_wdata = BYTE {4{wdata[7:0]}}, HALF {2{wdata[15:0]}}, WORD wdata.
  - Load: ram_be=0.
  - Loads the wait counter with RD_LATENCY-1. Next state is WAIT.
- WAIT:
  - ram_en=0 and ram_be=0.
  - Counter decrements each cycle.
  - When counter==0, a load captures the extracted ram_rdata into rdata at that edge; state -> DONE.
  - Stores wait the same duration, so timing is uniform.
- DONE (1 cycle): done=1, misalign as latched, then -> IDLE.
- Latency:
  - req sampled in cycle 0 -> done in cycle RD_LATENCY+2 (RD_LATENCY=1: done in cycle 3).
  - Misaligned request: done+misalign in cycle 1.
- req while busy is ignored: not queued, no side effects. The sequencer must wait for done.
- A back-to-back req in the same cycle as done is ignored. A req in the cycle after done is accepted.
- Misaligned access: no RAM enable, and rdata is unchanged.
- Load extraction uses the byte lane addr[1:0] (half lane addr[1]), sign-extended unless req_unsigned. For WORD, req_unsigned is ignored.
- No X on outputs after reset; ram_addr and ram_wdata may hold stale values when ram_en=0.

Decomposition:
- Shared package mem_pkg holds:
  - size_t enum (BYTE/HALF/WORD).
  - mau_state_t enum (IDLE/ISSUE/WAIT/DONE).
  - Constants for the byte-enable base masks.
- One combinational sub-module mem_load_align takes (ram_rdata, addr[1:0], size, unsigned) and returns the extended 32-bit value.
- The store lane-steering stays inline.

Test Plan:
- Reset mid-WAIT (RD_LATENCY=3, assert reset_n=0 in WAIT) -> busy, ram_en and rdata are 0 immediately; the next req after release completes normally.
- Word store then word load, addr 0x0010, wdata 0xDEADBEEF:
  - Store: ram_be=4'b1111 and ram_addr=0x004 in the ISSUE cycle.
  - Load: rdata=0xDEADBEEF with done in cycle 3 (RD_LATENCY=1).
- Byte load, signed and unsigned, from 0x0013 with RAM word 0x80FF7F01 -> signed rdata=0xFFFFFF80; unsigned rdata=0x00000080.
- Half store wdata 0x1234 at 0x0002 -> ram_be=4'b1100, ram_wdata=0x12341234; a following half load from 0x0002 gives rdata=0x00001234.
- Word load at 0x0006 -> done and misalign both high in cycle 1; ram_en never asserted; rdata unchanged.
- req held high across a whole access -> exactly one done; a second access starts only from the IDLE cycle after DONE.
